// File: rtl/frame_buffer_feed.sv
// Game-step segment generator: each tick draws the pipe and bird outlines as
// 8 line segments into a FIFO that feeds a line drawer. Optional: GRAVITY_EN.
module frame_buffer_feed #(
  parameter int unsigned PIPE_W = 20,
  parameter int unsigned PIPE_H = 200,
  parameter int unsigned BIRD_X = 100,
  parameter int unsigned BIRD_S = 8,
  parameter int unsigned SCR_W  = 640,
  parameter int unsigned SCR_H  = 480,
  parameter int unsigned DEPTH  = 16
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        tick,
  input  logic        flap,
  input  logic        line_ready,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic        seg_valid,
  output logic        clear,
  output logic        fifo_empty,
  output logic        fifo_full
);

  localparam int unsigned CW        = 11;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned NW        = AW + 1;
  localparam int unsigned FLAP_STEP = 8;

  typedef struct packed {
    logic [CW-1:0] x0;
    logic [CW-1:0] y0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y1;
  } seg_t;

  typedef enum logic [1:0] {IDLE, CLEAR, EMIT, UPDATE} state_t;

  state_t        state, state_next;
  logic [2:0]    seg_idx;
  logic [CW-1:0] pipe_x, bird_y;
  logic          flap_q;
  logic          wr_en, pop, clear_next;
  logic [CW-1:0] xl, xr, yt, yb;
  seg_t          wr_seg;

  seg_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count, count_next;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; EMIT only advances on an accepted write
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = CLEAR;
      CLEAR:   state_next = EMIT;
      EMIT:    if (wr_en && seg_idx == 3'd7) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    wr_en      = 1'b0;
    clear_next = 1'b0;
    if (state == EMIT && !fifo_full) wr_en = 1'b1;
    if (state_next == CLEAR)         clear_next = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) clear <= 1'b0;
    else       clear <= clear_next;
  end

  // Segment index 0-3 walks the pipe rectangle, 4-7 the bird square, clockwise
  always_comb begin
    if (seg_idx[2]) begin
      xl = CW'(BIRD_X);
      xr = CW'(BIRD_X + BIRD_S - 1);
      yt = bird_y;
      yb = bird_y + CW'(BIRD_S - 1);
    end else begin
      xl = pipe_x;
      xr = pipe_x + CW'(PIPE_W - 1);
      yt = '0;
      yb = CW'(PIPE_H - 1);
    end
    wr_seg = {xl, yt, xr, yt};
    case (seg_idx[1:0])
      2'd1:    wr_seg = {xr, yt, xr, yb};
      2'd2:    wr_seg = {xr, yb, xl, yb};
      2'd3:    wr_seg = {xl, yb, xl, yt};
      default: wr_seg = {xl, yt, xr, yt};
    endcase
  end

  // Game state: flap latched at the accepted tick, applied in UPDATE
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      seg_idx <= '0;
      flap_q  <= 1'b0;
      pipe_x  <= CW'(SCR_W - PIPE_W);
      bird_y  <= CW'((SCR_H - BIRD_S) / 2);
    end else begin
      if (state == IDLE && tick) flap_q <= flap;
      if (wr_en) seg_idx <= seg_idx + 3'd1;
      if (state == UPDATE) begin
        if (pipe_x == '0) pipe_x <= CW'(SCR_W - PIPE_W);
        else              pipe_x <= pipe_x - CW'(1);
        if (flap_q) begin
          if (bird_y < CW'(FLAP_STEP)) bird_y <= '0;
          else                         bird_y <= bird_y - CW'(FLAP_STEP);
        end
`ifdef GRAVITY_EN
        else if (bird_y >= CW'(SCR_H - BIRD_S)) bird_y <= CW'(SCR_H - BIRD_S);
        else                                    bird_y <= bird_y + CW'(1);
`endif
      end
    end
  end

  // Segment FIFO (DEPTH must be a power of two so the pointers wrap naturally)
  assign pop = !fifo_empty && line_ready && !seg_valid;

  always_comb begin
    count_next = count;
    case ({wr_en, pop})
      2'b10:   count_next = count + NW'(1);
      2'b01:   count_next = count - NW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset && wr_en) mem[wr_ptr] <= wr_seg;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count      <= count_next;
      fifo_empty <= (count_next == '0);
      fifo_full  <= (count_next == NW'(DEPTH));
    end
  end

  // Feeder output: endpoints hold until the next strobe
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x0        <= '0;
      y0        <= '0;
      x1        <= '0;
      y1        <= '0;
      seg_valid <= 1'b0;
    end else begin
      seg_valid <= pop;
      if (pop) {x0, y0, x1, y1} <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_frame_buffer_feed.sv
// Directed bench for frame_buffer_feed: frame scoreboard plus hand-computed
// spot checks of segment endpoints, stalls, saturation, wrap and reset.
`timescale 1ns/1ps
module tb_frame_buffer_feed;

  logic        CLOCK_50 = 1'b0;
  logic        reset, tick, flap, line_ready;
  logic [10:0] x0, y0, x1, y1;
  logic        seg_valid, clear, fifo_empty, fifo_full;

  int checks   = 0;
  int failures = 0;

  int          m_pipe_x, m_bird_y;
  logic [43:0] exp_q [$];
  logic [43:0] rx_log [$];
  int          clear_cnt = 0;
  logic        prev_valid = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  frame_buffer_feed dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tick       (tick),
    .flap       (flap),
    .line_ready (line_ready),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .seg_valid  (seg_valid),
    .clear      (clear),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [43:0] seg(input int a, input int b, input int c, input int d);
    return {11'(a), 11'(b), 11'(c), 11'(d)};
  endfunction

  // Reference frame: clockwise outlines, then the game-step update
  task automatic model_frame(input logic f);
    int xl, xr, bt, bb;
    xl = m_pipe_x;
    xr = m_pipe_x + 19;
    exp_q.push_back(seg(xl, 0, xr, 0));
    exp_q.push_back(seg(xr, 0, xr, 199));
    exp_q.push_back(seg(xr, 199, xl, 199));
    exp_q.push_back(seg(xl, 199, xl, 0));
    bt = m_bird_y;
    bb = m_bird_y + 7;
    exp_q.push_back(seg(100, bt, 107, bt));
    exp_q.push_back(seg(107, bt, 107, bb));
    exp_q.push_back(seg(107, bb, 100, bb));
    exp_q.push_back(seg(100, bb, 100, bt));
    m_pipe_x = (m_pipe_x == 0) ? 620 : m_pipe_x - 1;
    if (f) m_bird_y = (m_bird_y < 8) ? 0 : m_bird_y - 8;
`ifdef GRAVITY_EN
    else m_bird_y = (m_bird_y >= 472) ? 472 : m_bird_y + 1;
`endif
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (seg_valid) begin
        rx_log.push_back({x0, y0, x1, y1});
        check("seg_gap", 64'(prev_valid), 64'(0));
        check("seg_expected_pending", 64'(exp_q.size() == 0), 64'(0));
        if (exp_q.size() != 0) check("seg_order", 64'({x0, y0, x1, y1}), 64'(exp_q.pop_front()));
      end
      if (clear) clear_cnt++;
    end
    prev_valid = seg_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_tick(input logic f, input bit accepted);
    tick = 1'b1;
    flap = f;
    step(1);
    tick = 1'b0;
    flap = 1'b0;
    if (accepted) model_frame(f);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !fifo_empty) && n < budget) begin
      step(1);
      n++;
    end
    step(3);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_empty"}, 64'(fifo_empty), 64'(1));
  endtask

  initial begin
    int base;
    reset      = 1'b1;
    tick       = 1'b0;
    flap       = 1'b0;
    line_ready = 1'b0;
    m_pipe_x   = 620;
    m_bird_y   = 236;
    step(3);
    check("rst_xy", 64'({x0, y0, x1, y1}), 64'(0));
    check("rst_valid", 64'(seg_valid), 64'(0));
    check("rst_clear", 64'(clear), 64'(0));
    check("rst_empty", 64'(fifo_empty), 64'(1));
    check("rst_full", 64'(fifo_full), 64'(0));
    reset = 1'b0;
    step(2);

    // One frame with the drawer busy: 8 entries queue up
    clear_cnt = 0;
    do_tick(1'b0, 1'b1);
    step(14);
    check("f1_clear_pulses", 64'(clear_cnt), 64'(1));
    check("f1_empty", 64'(fifo_empty), 64'(0));
    check("f1_full", 64'(fifo_full), 64'(0));
    check("f1_no_output", 64'(rx_log.size()), 64'(0));

    line_ready = 1'b1;
    drain("f1", 200);
    check("f1_count", 64'(rx_log.size()), 64'(8));
    check("f1_seg1", 64'(rx_log[0]), 64'(seg(620, 0, 639, 0)));
    check("f1_seg5", 64'(rx_log[4]), 64'(seg(100, 236, 107, 236)));

    // Three frames into a stalled drawer: FIFO fills, third frame stalls
    line_ready = 1'b0;
    base = rx_log.size();
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0, 1'b1);
      step(16);
    end
    check("stall_full", 64'(fifo_full), 64'(1));
    check("stall_empty", 64'(fifo_empty), 64'(0));
    do_tick(1'b1, 1'b0);
    step(10);
    check("stall_still_full", 64'(fifo_full), 64'(1));
    check("stall_no_output", 64'(rx_log.size()), 64'(base));
    line_ready = 1'b1;
    drain("stall", 400);
    check("stall_count", 64'(rx_log.size() - base), 64'(24));
    check("stall_first", 64'(rx_log[base]), 64'(seg(619, 0, 638, 0)));
    check("stall_frame3", 64'(rx_log[base + 16]), 64'(seg(617, 0, 636, 0)));
    check("stall_last", 64'(rx_log[base + 23]), 64'(seg(100, 243, 100, 236)));

    // 40 flaps: bird climbs to the top and saturates
    for (int i = 0; i < 40; i++) begin
      do_tick(1'b1, 1'b1);
      step(20);
    end
    drain("flap", 200);
    base = rx_log.size() - 8;
    check("flap_last_pipe", 64'(rx_log[base]), 64'(seg(577, 0, 596, 0)));
    check("flap_last_bird", 64'(rx_log[base + 4]), 64'(seg(100, 0, 107, 0)));

    // Run the pipe to the left edge and through the wrap
    while (m_pipe_x != 0) begin
      do_tick(1'b0, 1'b1);
      step(20);
    end
    do_tick(1'b0, 1'b1);
    step(20);
    do_tick(1'b0, 1'b1);
    step(20);
    drain("wrap", 200);
    check("wrap_at_zero", 64'(rx_log[rx_log.size() - 16]), 64'(seg(0, 0, 19, 0)));
    check("wrap_after", 64'(rx_log[rx_log.size() - 8]), 64'(seg(620, 0, 639, 0)));

    // Reset in the middle of EMIT discards the partial frame
    line_ready = 1'b0;
    do_tick(1'b0, 1'b0);
    step(4);
    reset = 1'b1;
    step(1);
    exp_q.delete();
    m_pipe_x = 620;
    m_bird_y = 236;
    check("mid_rst_xy", 64'({x0, y0, x1, y1}), 64'(0));
    check("mid_rst_valid", 64'(seg_valid), 64'(0));
    check("mid_rst_clear", 64'(clear), 64'(0));
    check("mid_rst_empty", 64'(fifo_empty), 64'(1));
    check("mid_rst_full", 64'(fifo_full), 64'(0));
    reset = 1'b0;
    line_ready = 1'b1;
    step(2);
    base = rx_log.size();
    do_tick(1'b0, 1'b1);
    step(20);
    drain("post_rst", 200);
    check("post_rst_count", 64'(rx_log.size() - base), 64'(8));
    check("post_rst_seg1", 64'(rx_log[base]), 64'(seg(620, 0, 639, 0)));
    check("post_rst_seg5", 64'(rx_log[base + 4]), 64'(seg(100, 236, 107, 236)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
